edge_event_capture: RTL and testbench
=====================================

EDGE_EVENT_CAPTURE -- requirements
Module: edge_event_capture

Interface
REQ-001 Parameter NUM_PIXELS, default 1: number of independent comparator channels, legal range 1..64.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, legal range 0..4; 0 means comp is already in the clk domain.
REQ-003 Parameter FILT_CYCLES, default 1: consecutive stable cycles required before a level change is accepted, legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 comp  input  NUM_PIXELS  raw comparator outputs, possibly asynchronous.
REQ-007 mode  input  2  edge select: 00 rising, 01 falling, 10 both, 11 disabled.
REQ-008 clr  input  NUM_PIXELS  per-channel clear request for pending and overrun, level-sampled each cycle.
REQ-009 enable  output  NUM_PIXELS  one-cycle, registered pulse per qualifying edge.
REQ-010 pending  output  NUM_PIXELS  sticky flag set by a qualifying edge.
REQ-011 overrun  output  NUM_PIXELS  sticky flag set by a qualifying edge while pending is already set.

Function
REQ-012 Each channel SHALL pass comp[i] through SYNC_STAGES flops to give the synchronised level s[i].
REQ-013 Each channel SHALL hold a filtered level f[i] and a stability counter of width clog2(FILT_CYCLES+1).
- When s[i] equals f[i]: the counter clears to 0.
- When s[i] differs from f[i]: the counter increments.
- When s[i] differs from f[i] for FILT_CYCLES consecutive edges: f[i] takes s[i] and the counter clears.
- The counter SHALL never wrap.
REQ-014 Any s[i] pulse shorter than FILT_CYCLES cycles SHALL leave f[i] unchanged and produce no event.
REQ-015 A qualifying edge is an f[i] transition that matches mode:
- 00: 0->1 transitions.
- 01: 1->0 transitions.
- 10: either direction.
- 11: none.
REQ-016 enable[i] SHALL go high exactly SYNC_STAGES+FILT_CYCLES+1 rising edges after the first edge that samples the new comp level, and SHALL stay high for exactly one cycle.
REQ-017 mode SHALL be applied to the f[i] transition itself, so a mode change affects only transitions occurring after it.
REQ-018 mode SHALL not alter the synchroniser, filter or counter state.
REQ-019 On a qualifying edge, pending[i] SHALL be set on the same clock edge that asserts enable[i].
REQ-020 clr[i]=1 with no simultaneous qualifying edge SHALL clear pending[i] and overrun[i] on the next edge.
REQ-021 clr[i]=1 in the same cycle as a qualifying edge SHALL leave pending[i]=1 and overrun[i]=0: the set wins and no overrun is recorded.
REQ-022 A qualifying edge while pending[i]=1 and clr[i]=0 SHALL set overrun[i]; the flag holds until cleared.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.

Reset
REQ-024 While reset_n=0, every output SHALL be 0 immediately (asynchronously), regardless of clk.
- Reset covers all sync flops, f[], counters and edge-history flops.
REQ-025 Reset deassertion is synchronised externally; the first clock edge with reset_n=1 is a normal operating cycle.
REQ-026 A comp[i] held high through reset release SHALL produce a rising qualifying edge after the REQ-016 latency, because f[i] resets to 0.
REQ-027 Reset asserted mid-filter or mid-pulse SHALL abort the operation; no enable pulse is emitted after release for the aborted transition.

Structure
REQ-028 Package edge_capture_pkg SHALL hold:
- the edge-mode enum with encodings 00/01/10/11 (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF);
- the parameter range constants.
REQ-029 A per-channel sub-module edge_filter_chan SHALL hold the synchroniser, filter counter, f register and edge qualification.
- It is instantiated NUM_PIXELS times in a generate loop.
- The top level holds the pending and overrun flags.
REQ-030 Out-of-range parameters SHALL cause an elaboration-time error.

Verification
REQ-031 SYNC_STAGES=2, FILT_CYCLES=3, mode=00, comp[0] 0->1 held: enable[0] high only on edge 6 after sampling and pending[0]=1 from that edge.
REQ-032 FILT_CYCLES=3, comp[0] high for 2 cycles, then low: enable, pending and overrun remain 0 throughout.
REQ-033 mode=10 and comp toggles 0->1->0 with 10 cycles between toggles: exactly two enable pulses; overrun=1 after the second pulse with no clr.
REQ-034 clr[0] asserted in the exact cycle enable[0] pulses while pending[0]=1: pending stays 1 and overrun stays 0.
- The next clr with no edge clears pending to 0.
REQ-035 NUM_PIXELS=4, comp=4'b1010 rising together under mode=00: enable=4'b1010 in one cycle; mode=11 then gives no pulses for any transition.
REQ-036 comp[0]=1 through reset, then reset_n pulsed low mid-filter: outputs drop to 0 asynchronously, and after release a single enable follows REQ-016 latency.

Source files
------------

// File: rtl/edge_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_capture_pkg
// Purpose  : Shared edge-mode encoding, parameter limits and edge-match helper.
// Revision : 1.0
// ============================================================================
package edge_capture_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  localparam int C_NUM_PIXELS_MIN  = 1;
  localparam int C_NUM_PIXELS_MAX  = 64;
  localparam int C_SYNC_STAGES_MIN = 0;
  localparam int C_SYNC_STAGES_MAX = 4;
  localparam int C_FILT_CYCLES_MIN = 1;
  localparam int C_FILT_CYCLES_MAX = 255;

  // True when a filtered-level change to new_level qualifies under mode.
  function automatic logic edge_match(input edge_mode_e mode, input logic new_level);
    logic m;
    m = 1'b0;
    case (mode)
      EDGE_RISE: m = new_level;
      EDGE_FALL: m = ~new_level;
      EDGE_BOTH: m = 1'b1;
      default:   m = 1'b0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_filter_chan.sv
`default_nettype none
// ============================================================================
// Module   : edge_filter_chan
// Purpose  : One channel: synchroniser, stability filter and edge qualifier.
// Revision : 1.0
// ============================================================================
module edge_filter_chan
  import edge_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_comp,
  input  logic [1:0] i_mode,
  output logic       o_hit,
  output logic       o_enable
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(FILT_CYCLES - 1);

  logic          w_s;
  logic          r_f;
  logic [CW-1:0] r_cnt;
  logic          r_hit;
  logic          r_en;
  edge_mode_e    w_mode;

  assign w_mode = edge_mode_e'(i_mode);

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= i_comp;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end else begin : g_nosync
      assign w_s = i_comp;
    end
  endgenerate

  // r_hit marks the cycle after f changed; r_en delays it so the pulse
  // lands SYNC_STAGES+FILT_CYCLES+1 edges after comp is first sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f   <= 1'b0;
      r_cnt <= '0;
      r_hit <= 1'b0;
      r_en  <= 1'b0;
    end else begin
      r_en  <= r_hit;
      r_hit <= 1'b0;
      if (w_s == r_f) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_f   <= w_s;
        r_cnt <= '0;
        r_hit <= edge_match(w_mode, w_s);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_hit    = r_hit;
  assign o_enable = r_en;

endmodule
`default_nettype wire

// File: rtl/edge_event_capture.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_capture
// Purpose  : Multi-channel filtered edge capture with sticky pending/overrun.
// Revision : 1.0
// ============================================================================
module edge_event_capture
  import edge_capture_pkg::*;
#(
  parameter int NUM_PIXELS  = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_PIXELS-1:0] comp,
  input  logic [1:0]            mode,
  input  logic [NUM_PIXELS-1:0] clr,
  output logic [NUM_PIXELS-1:0] enable,
  output logic [NUM_PIXELS-1:0] pending,
  output logic [NUM_PIXELS-1:0] overrun
);

  generate
    if (NUM_PIXELS < C_NUM_PIXELS_MIN || NUM_PIXELS > C_NUM_PIXELS_MAX) begin : g_bad_np
      $error("edge_event_capture: NUM_PIXELS out of range");
    end
    if (SYNC_STAGES < C_SYNC_STAGES_MIN || SYNC_STAGES > C_SYNC_STAGES_MAX) begin : g_bad_ss
      $error("edge_event_capture: SYNC_STAGES out of range");
    end
    if (FILT_CYCLES < C_FILT_CYCLES_MIN || FILT_CYCLES > C_FILT_CYCLES_MAX) begin : g_bad_fc
      $error("edge_event_capture: FILT_CYCLES out of range");
    end
  endgenerate

  logic [NUM_PIXELS-1:0] w_hit;
  logic [NUM_PIXELS-1:0] r_pend;
  logic [NUM_PIXELS-1:0] r_ovr;

  generate
    for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_chan
      edge_filter_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES)
      ) u_chan (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_comp   (comp[gi]),
        .i_mode   (mode),
        .o_hit    (w_hit[gi]),
        .o_enable (enable[gi])
      );
    end
  endgenerate

  // A clear that overlaps an event (its set edge or its visible enable
  // cycle) keeps pending and drops overrun: the set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
      r_ovr  <= '0;
    end else begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        if (w_hit[i]) begin
          r_pend[i] <= 1'b1;
          r_ovr[i]  <= clr[i] ? 1'b0 : (r_ovr[i] | r_pend[i]);
        end else if (clr[i]) begin
          r_pend[i] <= enable[i];
          r_ovr[i]  <= 1'b0;
        end
      end
    end
  end

  assign pending = r_pend;
  assign overrun = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_event_capture
// Purpose  : Scoreboard bench for edge_event_capture against a history model.
// Revision : 1.0
// ============================================================================
module tb_edge_event_capture;

  localparam int NP   = 4;
  localparam int SS   = 2;
  localparam int FC   = 3;
  localparam int HMAX = 8192;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NP-1:0] comp;
  logic [1:0]    mode;
  logic [NP-1:0] clr;
  logic [NP-1:0] enable;
  logic [NP-1:0] pending;
  logic [NP-1:0] overrun;

  always #5 clk = ~clk;

  edge_event_capture #(
    .NUM_PIXELS  (NP),
    .SYNC_STAGES (SS),
    .FILT_CYCLES (FC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .comp    (comp),
    .mode    (mode),
    .clr     (clr),
    .enable  (enable),
    .pending (pending),
    .overrun (overrun)
  );

  typedef struct packed {
    logic [NP-1:0] en;
    logic [NP-1:0] pe;
    logic [NP-1:0] ov;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  // Reference model: comp history since reset plus sticky flags.
  logic [NP-1:0] hist [HMAX];
  int            e;
  logic [NP-1:0] m_f, m_sched, m_en, m_pe, m_ov;

  task automatic chk(input string nm, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
  endtask

  function automatic logic s_at(input int k, input int ch);
    return (k - SS >= 1) ? hist[k-SS][ch] : 1'b0;
  endfunction

  task automatic model_reset();
    e = 0; m_f = '0; m_sched = '0; m_en = '0; m_pe = '0; m_ov = '0;
  endtask

  // Level f flips when the last FC synchronised samples all disagree with it;
  // the enable for that flip appears one edge later.
  task automatic model_edge(input logic [NP-1:0] c, input logic [1:0] md, input logic [NP-1:0] cl);
    logic [NP-1:0] en_now, en_vis;
    exp_t x;
    bit run;
    e++;
    hist[e] = c;
    en_vis  = m_en;
    en_now  = m_sched;
    m_sched = '0;
    for (int ch = 0; ch < NP; ch++) begin
      run = 1'b1;
      for (int j = 0; j < FC; j++)
        if (e - j < 1 || s_at(e - j, ch) == m_f[ch]) run = 1'b0;
      if (run) begin
        m_f[ch] = ~m_f[ch];
        case (md)
          2'b00:   m_sched[ch] = m_f[ch];
          2'b01:   m_sched[ch] = ~m_f[ch];
          2'b10:   m_sched[ch] = 1'b1;
          default: m_sched[ch] = 1'b0;
        endcase
      end
      if (en_now[ch]) begin
        m_ov[ch] = cl[ch] ? 1'b0 : (m_ov[ch] | m_pe[ch]);
        m_pe[ch] = 1'b1;
      end else if (cl[ch] && en_vis[ch]) begin
        m_ov[ch] = 1'b0;
      end else if (cl[ch]) begin
        m_pe[ch] = 1'b0;
        m_ov[ch] = 1'b0;
      end
    end
    m_en = en_now;
    x.en = m_en; x.pe = m_pe; x.ov = m_ov;
    sbq.push_back(x);
  endtask

  task automatic step(input logic [NP-1:0] c, input logic [1:0] md, input logic [NP-1:0] cl);
    @(negedge clk);
    comp = c; mode = md; clr = cl;
    model_edge(c, md, cl);
  endtask

  task automatic do_reset(input int cyc, input logic [NP-1:0] c, input logic [1:0] md);
    exp_t z;
    z = '0;
    @(negedge clk);
    reset_n = 1'b0;
    comp = c;
    #1;
    chk("async_rst_enable", enable, '0);
    chk("async_rst_pending", pending, '0);
    chk("async_rst_overrun", overrun, '0);
    model_reset();
    repeat (cyc) begin
      @(negedge clk);
      sbq.push_back(z);
    end
    @(negedge clk);
    reset_n = 1'b1;
    comp = c; mode = md; clr = '0;
    model_edge(c, md, '0);
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      chk("enable", enable, x.en);
      chk("pending", pending, x.pe);
      chk("overrun", overrun, x.ov);
    end
  end

  initial begin
    logic [NP-1:0] c;
    logic [1:0]    md;
    logic [NP-1:0] cl;
    reset_n = 1'b0; comp = '0; mode = 2'b00; clr = '0;
    model_reset();
    #2;
    chk("reset_enable", enable, '0);
    chk("reset_pending", pending, '0);
    chk("reset_overrun", overrun, '0);

    // Clean rising edge after release, then sustained high level.
    do_reset(2, '0, 2'b00);
    repeat (3) step('0, 2'b00, '0);
    repeat (12) step('1, 2'b00, '0);
    // Fall under rising mode, then a 2-cycle glitch that must be filtered.
    repeat (12) step('0, 2'b00, '1);
    repeat (2) step('1, 2'b00, '0);
    repeat (12) step('0, 2'b00, '0);
    // Both-edge mode, two toggles without clear to reach overrun.
    step('0, 2'b10, '1);
    repeat (10) step('1, 2'b10, '0);
    repeat (12) step('0, 2'b10, '0);
    // Clear coinciding with the enable edge while pending is set.
    step('0, 2'b00, '0);
    for (int i = 1; i <= 10; i++) step('1, 2'b00, (i == 6) ? '1 : '0);
    step('1, 2'b00, '1);
    repeat (3) step('1, 2'b00, '0);
    // Simultaneous multi-channel rise, then disabled mode.
    repeat (12) step('0, 2'b00, '1);
    repeat (10) step(4'b1010, 2'b00, '0);
    for (int i = 0; i < 30; i++) step((i % 8 < 4) ? 4'b0101 : 4'b1010, 2'b11, '0);
    // High through reset, reset again mid-filter, single enable after.
    do_reset(3, '1, 2'b00);
    repeat (3) step('1, 2'b00, '0);
    do_reset(2, '1, 2'b00);
    repeat (10) step('1, 2'b00, '0);

    c = comp; md = 2'b10;
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < NP; ch++)
        if ($urandom_range(0, 5) == 0) c[ch] = ~c[ch];
      if ($urandom_range(0, 40) == 0) md = 2'($urandom_range(0, 3));
      for (int ch = 0; ch < NP; ch++) cl[ch] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 400) == 0) do_reset(2, c, md);
      else step(c, md, cl);
    end

    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d queued expected 0", sbq.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
